// File: rtl/arith_share_pkg.sv
// Shared definitions for the arithmetic-datapath arbiter: FSM states,
// operand/result widths and the grant-statistics counter format.
package arith_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 10;

    // Latency counter holds DP_LAT, which never exceeds 3.
    localparam int CNT_W = 2;

    // Per-requester grant counters (only built with ARB_GRANT_STATS_EN).
    localparam int                STAT_W   = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/arith_share_arb_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting at
// the index after ptr, wrapping from N-1 to 0, and returns the first hit as
// a one-hot grant plus its binary index.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Rotating first-one search; the earliest candidate after ptr wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
        any = found;
    end

endmodule

// File: rtl/arith_share_arb.sv
// arith_share_arb: round-robin arbiter that time-shares one arithmetic
// datapath of fixed latency DP_LAT between NUM_REQ requesters.
// One operation is outstanding at a time: IDLE grants, BUSY waits out the
// datapath latency, RESP holds the result until the consumer takes it.
// Optional feature: define ARB_GRANT_STATS_EN to add saturating per-requester
// grant counters on the grant_cnt port.
module arith_share_arb
    import arith_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DP_LAT  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][OPERAND_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [OPERAND_W-1:0]                dp_in,
    input  logic [RESULT_W-1:0]                 dp_out,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [RESULT_W-1:0]                 rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]          rsp_id
`ifdef ARB_GRANT_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0]      grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               grant_fire;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_picker (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state and grant decode; req_ready is forced low while reset is held.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !rst) begin
                    req_ready  = pick_gnt;
                    grant_fire = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);

    // Operand/owner capture on grant, latency countdown, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: rsp_data is cleared too, so a discarded result can never reappear.
            dp_in    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            cnt_q    <= '0;
            ptr_q    <= ID_W'(NUM_REQ - 1);
        end else if (grant_fire) begin
            dp_in  <= req_data[pick_idx];
            rsp_id <= pick_idx;
            cnt_q  <= CNT_W'(DP_LAT);
            ptr_q  <= pick_idx;
        end else if (state_q == ST_BUSY) begin
            if (cnt_q == '0) rsp_data <= dp_out;
            else             cnt_q    <= cnt_q - 1'b1;
        end
    end

`ifdef ARB_GRANT_STATS_EN
    // Saturating count of grants handed to each requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (grant_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_gnt[i] && grant_cnt[i] != STAT_MAX)
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arith_share_arb.sv
// Self-checking bench for arith_share_arb: a DP_LAT=2 instance (main) and a
// DP_LAT=0 instance, each fed by a behavioural datapath model.
// Directed vector table, hand-written corner sequences, then randomized
// traffic against a transaction-level reference model.
// Grant-counter checks are compiled when ARB_GRANT_STATS_EN is defined.
`timescale 1ns/1ps
module tb_arith_share_arb;

    localparam int N     = 4;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A (DP_LAT = 2)
    logic [N-1:0]      req_valid, req_ready;
    logic [N-1:0][3:0] req_data;
    logic [3:0]        dp_in;
    logic [9:0]        dp_out, rsp_data;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;

    // Instance B (DP_LAT = 0)
    logic [N-1:0]      req_valid_b, req_ready_b;
    logic [N-1:0][3:0] req_data_b;
    logic [3:0]        dp_in_b;
    logic [9:0]        dp_out_b, rsp_data_b;
    logic              rsp_valid_b, rsp_ready_b;
    logic [1:0]        rsp_id_b;

`ifdef ARB_GRANT_STATS_EN
    logic [N-1:0][7:0] grant_cnt, grant_cnt_b;
`endif

    bit wide;   // datapath model mode: 0 = x*x, 1 = x*x plus high bits
    int n_checks = 0;
    int n_errs   = 0;

    arith_share_arb #(.NUM_REQ(N), .DP_LAT(LAT_A)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .dp_in(dp_in), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    arith_share_arb #(.NUM_REQ(N), .DP_LAT(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
        .dp_in(dp_in_b), .dp_out(dp_out_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_data(rsp_data_b), .rsp_id(rsp_id_b)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(grant_cnt_b)
`endif
    );

    function automatic logic [9:0] fmodel(input logic [3:0] x, input bit w);
        logic [9:0] r;
        r = 10'(x) * 10'(x);
        if (w) r = r + {x[3:2], 8'h00};
        return r;
    endfunction

    // Datapath models: two-stage pipe for A, combinational for B.
    logic [9:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fmodel(dp_in, wide);
        p2 <= p1;
    end
    assign dp_out   = p2;
    assign dp_out_b = fmodel(dp_in_b, wide);

    // Round-robin rule: first valid index after the last grant, wrapping.
    function automatic int rr_ref(input logic [3:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = '0; req_valid_b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // One complete transaction; latency counted in edges after the grant edge.
    task automatic txn(input bit use_b, input logic [3:0] v, input logic [15:0] d,
                       input int exp_id, input logic [9:0] exp_res, input string tag);
        logic [3:0] gnt;
        int n, lat, exp_lat;
        bit seen;
        exp_lat = use_b ? 1 : LAT_A + 1;
        if (use_b) begin req_valid_b = v; req_data_b = d; rsp_ready_b = 1'b1; end
        else       begin req_valid   = v; req_data   = d; rsp_ready   = 1'b1; end
        gnt = '0; n = 0;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            gnt = use_b ? req_ready_b : req_ready;
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_grant", tag), 32'(gnt), 32'(4'b0001 << exp_id));
        if (use_b) req_valid_b = '0; else req_valid = '0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            seen = use_b ? rsp_valid_b : rsp_valid;
            if (!seen) begin @(posedge clk); #1; lat++; end
        end
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_data", tag), 32'(use_b ? rsp_data_b : rsp_data), 32'(exp_res));
        check($sformatf("%s_id", tag), 32'(use_b ? rsp_id_b : rsp_id), 32'(exp_id));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        int          id;
        logic [9:0]  res;
    } vec_t;

    vec_t vecs[6];

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] order [5];
        logic [3:0] g;
        logic [9:0] exp_res;
        int k, n, cnt, last, e, g_cyc, exp_id;
        bit outstanding, seen, exp_v;

        // Directed vectors, starting from the post-reset pointer.
        vecs[0] = '{4'b0001, 16'h0003, 0, 10'd9};
        vecs[1] = '{4'b1111, 16'h6521, 1, 10'd4};
        vecs[2] = '{4'b1001, 16'hF00E, 3, 10'd225};
        vecs[3] = '{4'b1011, 16'h0A0C, 0, 10'd144};
        vecs[4] = '{4'b0100, 16'h0D00, 2, 10'd169};
        vecs[5] = '{4'b0011, 16'h0087, 0, 10'd49};

        wide = 1'b0;
        rsp_ready = 1'b1; rsp_ready_b = 1'b1;
        req_data = 16'h1234; req_data_b = 16'h1234;

        // Reset state, with requests already pending.
        rst = 1'b1;
        req_valid = 4'b1111; req_valid_b = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_dp_in", 32'(dp_in), 32'h0);
        check("rst_req_ready_b", 32'(req_ready_b), 32'h0);
        req_valid = '0; req_valid_b = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            txn(1'b0, vecs[i].v, vecs[i].d, vecs[i].id, vecs[i].res, $sformatf("vec%0d", i));

        // Zero-latency datapath.
        txn(1'b1, 4'b0100, 16'h0700, 2, 10'd49, "lat0");

        // Continuous requests from everyone: strict rotation 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111; req_data = 16'h4321; rsp_ready = 1'b1;
        k = 0; n = 0;
        while (k < 5 && n < 60) begin
            @(negedge clk);
            g = req_ready;
            if (g != '0) begin order[k] = g; k++; end
            @(posedge clk); #1;
            n++;
        end
        req_valid = '0;
        check("rr_count", 32'(k), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(4'b0001 << (i % 4)));
        repeat (10) @(posedge clk);
        #1;

        // Backpressure: result held, nothing granted while RESP waits.
        req_valid = 4'b1111; req_data = 16'h9876; rsp_ready = 1'b0;
        g = '0; n = 0;
        while (g == '0 && n < 20) begin
            @(negedge clk); g = req_ready; @(posedge clk); #1; n++;
        end
        check("bp_grant", 32'(g), 32'h2);
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); seen = rsp_valid;
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_data%0d", i), 32'(rsp_data), 32'd49);
            check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd1);
            check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_last", 32'(rsp_valid), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'h0);
        check("bp_after_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;

        // Reset while BUSY: everything clears at once, operation is lost.
        req_valid = 4'b0010; req_data = 16'h00A0;
        g = '0; n = 0;
        while (g == '0 && n < 20) begin
            @(negedge clk); g = req_ready; @(posedge clk); #1; n++;
        end
        check("rb_grant", 32'(g), 32'h2);
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check("rb_rsp_data", 32'(rsp_data), 32'h0);
        check("rb_rsp_id", 32'(rsp_id), 32'h0);
        check("rb_dp_in", 32'(dp_in), 32'h0);
        check("rb_req_ready", 32'(req_ready), 32'h0);
        check("rb_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); if (rsp_valid) cnt++;
            @(posedge clk); #1;
        end
        check("rb_no_rsp", 32'(cnt), 32'h0);
        txn(1'b0, 4'b1111, 16'h1234, 0, 10'd16, "rb_next");

        // Randomized traffic against the transaction-level model.
        do_reset();
        wide = 1'b1;
        last = N - 1; outstanding = 1'b0; seen = 1'b0;
        g_cyc = 0; exp_id = 0; exp_res = '0;
        for (int c = 0; c < 800; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (!outstanding) begin
                e = rr_ref(req_valid, last);
                check("rnd_grant", 32'(req_ready), (e < 0) ? 32'h0 : 32'(4'b0001 << e));
                check("rnd_idle_rsp", 32'(rsp_valid), 32'h0);
                if (e >= 0) begin
                    outstanding = 1'b1; seen = 1'b0;
                    g_cyc = c; exp_id = e; last = e;
                    exp_res = fmodel(req_data[e], 1'b1);
                end
            end else begin
                check("rnd_busy_ready", 32'(req_ready), 32'h0);
                exp_v = seen || (c - g_cyc >= LAT_A + 2);
                check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (rsp_valid) begin
                    seen = 1'b1;
                    check("rnd_rsp_data", 32'(rsp_data), 32'(exp_res));
                    check("rnd_rsp_id", 32'(rsp_id), 32'(exp_id));
                    if (rsp_ready) outstanding = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

`ifdef ARB_GRANT_STATS_EN
        // 300 grants to requester 1 saturate its counter at 255.
        do_reset();
        wide = 1'b0;
        req_valid = 4'b0010; rsp_ready = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 300 && n < 3000) begin
            @(negedge clk); if (req_ready[1]) cnt++;
            @(posedge clk); #1; n++;
        end
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        check("st_grants", 32'(cnt), 32'd300);
        check("st_cnt1", 32'(grant_cnt[1]), 32'd255);
        check("st_cnt0", 32'(grant_cnt[0]), 32'd0);
        check("st_cnt2", 32'(grant_cnt[2]), 32'd0);
        check("st_cnt3", 32'(grant_cnt[3]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
